// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bundle: decoded ID fields in, registered EX fields plus the stall flag out.
interface id_ex_if;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [8:0]  id_ctrl;
  logic        id_uses_rt;
  logic        flush;
  logic        stall;
  logic [4:0]  ie_rs, ie_rt, ie_rd;
  logic [31:0] ie_rs_data, ie_rt_data, ie_imm;
  logic [8:0]  ie_ctrl;
  logic        ie_valid;
  logic        ie_init;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_ctrl, id_uses_rt, flush,
    input  stall, ie_rs, ie_rt, ie_rd, ie_rs_data, ie_rt_data, ie_imm,
           ie_ctrl, ie_valid, ie_init
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_ctrl, id_uses_rt, flush,
    output stall, ie_rs, ie_rt, ie_rd, ie_rs_data, ie_rt_data, ie_imm,
           ie_ctrl, ie_valid, ie_init
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_if.slave      bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  // ctrl layout: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
  localparam int MEM_READ = 7;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsData, rtData, imm;
  } exReg_t;

  exReg_t exQ, exD;
  logic   initQ;
  logic   rsHit, rtHit, hazard, bubble;

  // $0 never hazards, and a taken branch kills the consumer so no stall is needed
  assign rsHit  = (exQ.rt == bus.id_rs);
  assign rtHit  = bus.id_uses_rt & (exQ.rt == bus.id_rt);
  assign hazard = bus.id_valid & exQ.ctrl[MEM_READ] & (exQ.rt != 5'd0)
                & (rsHit | rtHit) & ~bus.flush;
  assign bubble = bus.flush | hazard;

  always_comb begin
    exD = '0;
    if (!bubble) begin
      exD.valid  = bus.id_valid;
      exD.ctrl   = bus.id_valid ? bus.id_ctrl : 9'd0;
      exD.rs     = bus.id_rs;
      exD.rt     = bus.id_rt;
      exD.rd     = bus.id_rd;
      exD.rsData = bus.id_rs_data;
      exD.rtData = bus.id_rt_data;
      exD.imm    = bus.id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ   <= '0;
      initQ <= 1'b1;
    end else begin
      exQ <= exD;
      if (!bubble && bus.id_valid) initQ <= 1'b0;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt <= 16'd0;
    else if (hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bus.stall      = hazard;
  assign bus.ie_valid   = exQ.valid;
  assign bus.ie_ctrl    = exQ.ctrl;
  assign bus.ie_rs      = exQ.rs;
  assign bus.ie_rt      = exQ.rt;
  assign bus.ie_rd      = exQ.rd;
  assign bus.ie_rs_data = exQ.rsData;
  assign bus.ie_rt_data = exQ.rtData;
  assign bus.ie_imm     = exQ.imm;
  assign bus.ie_init    = initQ;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written stall/reset sequences, random run vs model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_if bus();

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic [31:0] rsD, rtD, imm;
    logic [8:0] ctrl; logic usesRt, flush;
  } in_t;
  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic [31:0] rsD, rtD, imm;
    logic [8:0] ctrl; logic init;
  } ex_t;
  typedef struct {
    in_t in; logic expStall; logic expValid; logic [8:0] expCtrl;
    logic [4:0] expRs; logic expInit;
  } vec_t;

  int total = 0, bad = 0;
  ex_t m;
  int unsigned mCnt;
  in_t cur;
  int dutStalls;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mkIn(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic [8:0] ctrl, input logic flush);
    in_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.rd = rs ^ 5'h1F;
    i.rsD = $urandom; i.rtD = $urandom; i.imm = $urandom;
    i.ctrl = ctrl; i.usesRt = usesRt; i.flush = flush;
    return i;
  endfunction

  function automatic vec_t mkVec(input in_t i, input logic s, input logic ev,
                                 input logic [8:0] ec, input logic [4:0] ers, input logic ei);
    vec_t r;
    r.in = i; r.expStall = s; r.expValid = ev; r.expCtrl = ec; r.expRs = ers; r.expInit = ei;
    return r;
  endfunction

  task automatic drive(input in_t i);
    cur = i;
    bus.id_valid = i.v; bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
    bus.id_rs_data = i.rsD; bus.id_rt_data = i.rtD; bus.id_imm = i.imm;
    bus.id_ctrl = i.ctrl; bus.id_uses_rt = i.usesRt; bus.flush = i.flush;
  endtask

  // Load-use rule: the instruction in EX is a load whose nonzero destination is read by ID.
  function automatic logic mStall();
    logic uses;
    uses = (m.rt == cur.rs) || (cur.usesRt && m.rt == cur.rt);
    return cur.v && m.ctrl[7] && m.rt != 0 && uses && !cur.flush;
  endfunction

  task automatic resetModel();
    m = '{default: '0};
    m.init = 1'b1;
    mCnt = 0;
  endtask

  task automatic stepModel();
    ex_t n;
    logic s;
    s = mStall();
    if (s && mCnt < 32'hFFFF) mCnt++;
    n = '{default: '0};
    n.init = m.init;
    if (!(cur.flush || s)) begin
      n.v = cur.v; n.ctrl = cur.v ? cur.ctrl : 9'd0;
      n.rs = cur.rs; n.rt = cur.rt; n.rd = cur.rd;
      n.rsD = cur.rsD; n.rtD = cur.rtD; n.imm = cur.imm;
      if (cur.v) n.init = 1'b0;
    end
    m = n;
  endtask

  task automatic checkAll();
    chk("stall", bus.stall, mStall());
    chk("ie_valid", bus.ie_valid, m.v);
    chk("ie_ctrl", bus.ie_ctrl, m.ctrl);
    chk("ie_rs", bus.ie_rs, m.rs);
    chk("ie_rt", bus.ie_rt, m.rt);
    chk("ie_rd", bus.ie_rd, m.rd);
    chk("ie_rs_data", bus.ie_rs_data, m.rsD);
    chk("ie_rt_data", bus.ie_rt_data, m.rtD);
    chk("ie_imm", bus.ie_imm, m.imm);
    chk("ie_init", bus.ie_init, m.init);
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, mCnt);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAll();
    if (bus.stall === 1'b1) dutStalls++;
    @(posedge clk);
    stepModel();
    #1;
  endtask

  // Asserted between edges to exercise the asynchronous clear.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    chk("rst ie_valid", bus.ie_valid, 1'b0);
    chk("rst ie_ctrl", bus.ie_ctrl, 9'd0);
    chk("rst ie_rs", bus.ie_rs, 5'd0);
    chk("rst ie_rt_data", bus.ie_rt_data, 32'd0);
    chk("rst ie_init", bus.ie_init, 1'b1);
    chk("rst stall", bus.stall, 1'b0);
`ifdef ID_EX_STALL_CNT_EN
    chk("rst stall_cnt", stall_cnt, 16'd0);
`endif
    resetModel();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  localparam logic [8:0] LW = 9'h1B0, ALU = 9'h10A;
  vec_t tbl[11];

  initial begin
    resetModel();
    dutStalls = 0;
    drive(mkIn(1'b0, 5'd0, 5'd0, 1'b0, 9'd0, 1'b0));
    #2;
    doReset();

    tbl[0]  = mkVec(mkIn(1, 3, 0, 0, 9'h100, 0), 0, 1, 9'h100, 3, 0);
    tbl[1]  = mkVec(mkIn(1, 1, 5, 0, LW,     0), 0, 1, LW,     1, 0);
    tbl[2]  = mkVec(mkIn(1, 5, 9, 1, ALU,    0), 1, 0, 9'd0,   0, 0);
    tbl[3]  = mkVec(mkIn(1, 5, 9, 1, ALU,    0), 0, 1, ALU,    5, 0);
    tbl[4]  = mkVec(mkIn(1, 2, 0, 0, LW,     0), 0, 1, LW,     2, 0);
    tbl[5]  = mkVec(mkIn(1, 0, 0, 1, ALU,    0), 0, 1, ALU,    0, 0);
    tbl[6]  = mkVec(mkIn(1, 4, 7, 0, LW,     0), 0, 1, LW,     4, 0);
    tbl[7]  = mkVec(mkIn(1, 2, 7, 0, ALU,    0), 0, 1, ALU,    2, 0);
    tbl[8]  = mkVec(mkIn(1, 1, 6, 0, LW,     0), 0, 1, LW,     1, 0);
    tbl[9]  = mkVec(mkIn(1, 6, 3, 1, ALU,    1), 0, 0, 9'd0,   0, 0);
    tbl[10] = mkVec(mkIn(0, 3, 4, 0, 9'h1FF, 0), 0, 0, 9'd0,   3, 0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), bus.stall, tbl[i].expStall);
      @(posedge clk);
      stepModel();
      #2;
      chk($sformatf("vec%0d ie_valid", i), bus.ie_valid, tbl[i].expValid);
      chk($sformatf("vec%0d ie_ctrl", i), bus.ie_ctrl, tbl[i].expCtrl);
      chk($sformatf("vec%0d ie_rs", i), bus.ie_rs, tbl[i].expRs);
      chk($sformatf("vec%0d ie_init", i), bus.ie_init, tbl[i].expInit);
    end

    // Three separate load-use pairs, then an asynchronous reset mid-run.
    doReset();
    dutStalls = 0;
    for (int k = 0; k < 3; k++) begin
      drive(mkIn(1, 1, 5, 0, LW, 0));  cycle();
      drive(mkIn(1, 5, 2, 1, ALU, 0)); cycle();
      cycle();
    end
    chk("three stalls seen", dutStalls, 3);
`ifdef ID_EX_STALL_CNT_EN
    @(negedge clk);
    chk("stall_cnt three", stall_cnt, 16'd3);
    @(posedge clk); #1;
`endif
    doReset();
    drive(mkIn(1, 9, 4, 1, ALU, 0));
    cycle();
    @(negedge clk);
    chk("post-reset load ie_rs", bus.ie_rs, 5'd9);
    chk("post-reset ie_init", bus.ie_init, 1'b0);
    @(posedge clk); #1;

    for (int c = 0; c < 300; c++) begin
      in_t r;
      r = mkIn($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 9'($urandom), $urandom_range(0, 7) == 0);
      r.ctrl[7] = 1'($urandom_range(0, 1));
      drive(r);
      cycle();
      if (c == 150) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have id_valid  input  1  ID stage holds a real instruction.
REQ-004 SHALL have id_rs, id_rt, id_rd  input  5 each  decoded register numbers.
REQ-005 SHALL have id_rs_data, id_rt_data, id_imm  input  32 each  register-file read data and sign-extended immediate.
REQ-006 SHALL have id_ctrl  input  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]} in that bit order, MSB first.
REQ-007 SHALL have id_uses_rt  input  1  instruction reads rt as a source.
REQ-008 SHALL have flush  input  1  branch/jump taken; discard ID instruction.
REQ-009 SHALL have stall  output  1  load-use hazard; IF/ID and PC hold.
REQ-010 SHALL have ie_rs, ie_rt, ie_rd  output  5 each  registered register numbers; feed the forwarding unit as IE_RegRs/IE_RegRt.
REQ-011 SHALL have ie_rs_data, ie_rt_data, ie_imm  output  32 each  registered operands.
REQ-012 SHALL have ie_ctrl  output  9  registered control, same layout as id_ctrl.
REQ-013 SHALL have ie_valid  output  1  EX holds a real instruction.
REQ-014 SHALL have ie_init  output  1  pipeline not yet primed; drives the forwarding unit init input.

Function
REQ-015 SHALL assert stall combinationally iff id_valid & ie_ctrl.MemRead & ie_rt != 0 & (ie_rt == id_rs | (id_uses_rt & ie_rt == id_rt)) & !flush.
REQ-016 SHALL, each rising edge, select next register contents by priority: flush > stall > load.
REQ-017 SHALL on flush or stall load a bubble: ie_ctrl = 0, ie_valid = 0, ie_rs = ie_rt = ie_rd = 0, data fields = 0.
REQ-018 SHALL on load capture all id_* fields; ie_valid = id_valid; ie_ctrl = id_valid ? id_ctrl : 0.
REQ-019 SHALL give latency of exactly one cycle from ID inputs to ie_* outputs.
REQ-020 SHALL stall for exactly one cycle per load-use pair: the inserted bubble clears ie_ctrl.MemRead, so stall deasserts on the next cycle unless a new load occupies EX.
REQ-021 SHALL treat register 0 as never hazarding; a load targeting $0 causes no stall.
REQ-022 SHALL hold ie_init = 1 from reset until the first edge on which ie_valid is loaded as 1; ie_init then stays 0 until the next reset.
REQ-023 SHALL not change ie_init on flush or stall edges.

Reset
REQ-024 SHALL on rst_n = 0 immediately clear every ie_* register to 0, set ie_init = 1; stall then evaluates to 0.
REQ-025 SHALL, after reset release mid-operation, ignore any previously captured instruction; the first post-reset edge loads normally.

Configuration
REQ-026 SHALL, when ID_EX_STALL_CNT_EN is defined, add output stall_cnt (16 bits): increments on each edge where stall = 1, saturates at 16'hFFFF, cleared by reset.
REQ-027 SHALL, when ID_EX_STALL_CNT_EN is undefined, omit stall_cnt and its register entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, then id_valid=1, id_rs=3, id_ctrl=9'h100 -> next cycle ie_rs=3, ie_ctrl=9'h100, ie_valid=1, ie_init falls 1->0.
REQ-029 SHALL cover: EX holds lw with ie_rt=5, MemRead=1; ID has id_rs=5 -> stall=1 that cycle; next cycle ie_ctrl=0, ie_valid=0, stall=0; following cycle ID instruction loads.
REQ-030 SHALL cover: lw to ie_rt=0, ID id_rs=0 -> stall=0, no bubble.
REQ-031 SHALL cover: hazard condition true and flush=1 simultaneously -> stall=0, bubble loaded.
REQ-032 SHALL cover: id_uses_rt=0, ie_rt=7 load, id_rt=7, id_rs=2 -> stall=0.
REQ-033 SHALL cover (ID_EX_STALL_CNT_EN defined): three separate load-use stalls -> stall_cnt=3; rst_n pulse low mid-run -> stall_cnt=0, ie_init=1, ie_ctrl=0 asynchronously.
